// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard/forwarding controller:
// forwarding select encodings, FSM states and branch-resolve stage ids.
package pipeline_ctrl_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam int unsigned BR_ID  = 1;
   localparam int unsigned BR_EX  = 2;
   localparam int unsigned BR_MEM = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_select.sv
// Per-operand forwarding mux select: EX_MEM result beats MEM_WB write-back,
// the zero register is never forwarded and a load in EX_MEM is never a source.
module forward_select
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic [REG_W-1:0] i_ex_src,
   input  logic [REG_W-1:0] i_mem_rd,
   input  logic             i_mem_regwrite,
   input  logic             i_mem_memread,
   input  logic [REG_W-1:0] i_wb_rd,
   input  logic             i_wb_regwrite,
   output logic [1:0]       o_sel
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem_regwrite && !i_mem_memread &&
                      (i_mem_rd != ZR) && (i_mem_rd == i_ex_src);
   assign w_wb_hit  = i_wb_regwrite && (i_wb_rd != ZR) && (i_wb_rd == i_ex_src);

   always_comb begin
      o_sel = FWD_REGFILE;
      if (w_mem_hit)
         o_sel = FWD_EXMEM;
      else if (w_wb_hit)
         o_sel = FWD_MEMWB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: multi-cycle load-use
// stall FSM, operand forwarding, branch flush decode and saturating perf counters.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned ZERO_REG = 31,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned BR_STAGE = 3,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_rn_used,
   input  logic             id_rm_used,
   input  logic [REG_W-1:0] ex_rn,
   input  logic [REG_W-1:0] ex_rm,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_regwrite,
   input  logic             mem_memread,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_regwrite,
   input  logic             branch_taken,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int unsigned       CW = $clog2(LOAD_LAT) + 1;
   localparam logic [REG_W-1:0]  ZR = REG_W'(ZERO_REG);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_events;
   logic             w_hazard;
   logic             w_stall;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   assign w_hazard = ex_memread && ex_regwrite && (ex_rd != ZR) &&
                     ((id_rn_used && (id_rn == ex_rd)) || (id_rm_used && (id_rm == ex_rd)));

   // The first bubble is issued from RUN; STALL covers the remaining LOAD_LAT-1,
   // so the total never depends on what the pipeline holds meanwhile.
   assign w_stall = !branch_taken &&
                    (((r_state == RUN) && w_hazard) || (r_state == STALL));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else if (branch_taken) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_hazard && (LOAD_LAT > 1)) begin
                  r_state <= STALL;
                  r_cnt   <= CW'(LOAD_LAT - 1);
               end
            end
            STALL: begin
               if (r_cnt <= CW'(1)) begin
                  r_state <= RUN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= RUN;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         if (branch_taken && (r_flush_events != '1))
            r_flush_events <= r_flush_events + CNT_W'(1);
      end
   end

   forward_select #(
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG)
   ) u_fwd_a (
      .i_ex_src       (ex_rn),
      .i_mem_rd       (mem_rd),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_memread  (mem_memread),
      .i_wb_rd        (wb_rd),
      .i_wb_regwrite  (wb_regwrite),
      .o_sel          (w_fwd_a)
   );

   forward_select #(
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG)
   ) u_fwd_b (
      .i_ex_src       (ex_rm),
      .i_mem_rd       (mem_rd),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_memread  (mem_memread),
      .i_wb_rd        (wb_rd),
      .i_wb_regwrite  (wb_regwrite),
      .o_sel          (w_fwd_b)
   );

   always_comb begin
      pc_write     = !w_stall;
      if_id_write  = !w_stall;
      id_ex_bubble = w_stall;
      if_id_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      forward_a    = w_fwd_a;
      forward_b    = w_fwd_b;
      if (branch_taken) begin
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_bubble = (BR_STAGE >= BR_EX);
         ex_mem_flush = (BR_STAGE == BR_MEM);
      end
      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         ex_mem_flush = 1'b1;
         forward_a    = FWD_REGFILE;
         forward_b    = FWD_REGFILE;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances share stimulus,
// one with LOAD_LAT=1/BR_STAGE=2/3-bit counters, one with LOAD_LAT=3/BR_STAGE=3.
module tb_pipeline_hazard_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
   logic       id_rn_used, id_rm_used, ex_regwrite, ex_memread;
   logic       mem_regwrite, mem_memread, wb_regwrite, branch_taken;

   logic [1:0]  fa1, fb1, fa3, fb3;
   logic        pcw1, ifw1, iff1, bub1, emf1;
   logic        pcw3, ifw3, iff3, bub3, emf3;
   logic [2:0]  sc1, fe1;
   logic [31:0] sc3, fe3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   pipeline_hazard_ctrl #(
      .REG_W(5), .ZERO_REG(31), .LOAD_LAT(1), .BR_STAGE(2), .CNT_W(3)
   ) u_l1 (
      .clock(clock), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
      .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .mem_memread(mem_memread), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .branch_taken(branch_taken),
      .forward_a(fa1), .forward_b(fb1), .pc_write(pcw1), .if_id_write(ifw1),
      .if_id_flush(iff1), .id_ex_bubble(bub1), .ex_mem_flush(emf1),
      .stall_cycles(sc1), .flush_events(fe1)
   );

   pipeline_hazard_ctrl #(
      .REG_W(5), .ZERO_REG(31), .LOAD_LAT(3), .BR_STAGE(3), .CNT_W(32)
   ) u_l3 (
      .clock(clock), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
      .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .mem_memread(mem_memread), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .branch_taken(branch_taken),
      .forward_a(fa3), .forward_b(fb3), .pc_write(pcw3), .if_id_write(ifw3),
      .if_id_flush(iff3), .id_ex_bubble(bub3), .ex_mem_flush(emf3),
      .stall_cycles(sc3), .flush_events(fe3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      id_rn = '0; id_rm = '0; id_rn_used = 1'b0; id_rm_used = 1'b0;
      ex_rn = '0; ex_rm = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0;
      wb_rd = '0; wb_regwrite = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      ex_rd = rd; ex_memread = 1'b1; ex_regwrite = 1'b1;
      id_rn = rd; id_rn_used = 1'b1; id_rm = 5'd2; id_rm_used = 1'b1;
   endtask

   initial begin
      clear_in();
      reset = 1'b0;
      mem_rd = 5'd3; mem_regwrite = 1'b1; ex_rn = 5'd3;
      #1;
      chk("rst_pc_write", {31'd0, pcw3}, 32'd0);
      chk("rst_if_id_write", {31'd0, ifw3}, 32'd0);
      chk("rst_if_id_flush", {31'd0, iff3}, 32'd1);
      chk("rst_id_ex_bubble", {31'd0, bub3}, 32'd1);
      chk("rst_ex_mem_flush", {31'd0, emf3}, 32'd1);
      chk("rst_forward_a", {30'd0, fa3}, 32'd0);
      chk("rst_stall_cycles", sc3, 32'd0);
      chk("rst_flush_events", fe3, 32'd0);

      @(negedge clock);
      reset = 1'b1;
      clear_in();
      #1;
      chk("idle_pc_write", {31'd0, pcw3}, 32'd1);
      chk("idle_bubble", {31'd0, bub3}, 32'd0);
      chk("idle_if_id_flush", {31'd0, iff3}, 32'd0);

      // LDUR X1 in EX, ADD reads X1 in ID
      set_load_use(5'd1);
      #1;
      chk("lu1_pc_write", {31'd0, pcw1}, 32'd0);
      chk("lu1_if_id_write", {31'd0, ifw1}, 32'd0);
      chk("lu1_bubble", {31'd0, bub1}, 32'd1);
      chk("lu3_pc_write_c1", {31'd0, pcw3}, 32'd0);

      @(negedge clock);
      clear_in();
      id_rn = 5'd1; id_rn_used = 1'b1;
      ex_rn = 5'd1;
      mem_rd = 5'd1; mem_regwrite = 1'b1; mem_memread = 1'b1;
      #1;
      chk("lu1_release_pc_write", {31'd0, pcw1}, 32'd1);
      chk("lu1_release_bubble", {31'd0, bub1}, 32'd0);
      chk("lu1_stall_cycles", {29'd0, sc1}, 32'd1);
      chk("load_in_exmem_not_fwd", {30'd0, fa1}, 32'd0);
      chk("lu3_pc_write_c2", {31'd0, pcw3}, 32'd0);
      chk("lu3_bubble_c2", {31'd0, bub3}, 32'd1);
      chk("lu3_stall_cycles_c2", sc3, 32'd1);

      @(negedge clock);
      clear_in();
      ex_rn = 5'd1; wb_rd = 5'd1; wb_regwrite = 1'b1;
      #1;
      chk("lu1_fwd_memwb", {30'd0, fa1}, 32'd1);
      chk("lu3_pc_write_c3", {31'd0, pcw3}, 32'd0);
      chk("lu3_stall_cycles_c3", sc3, 32'd2);

      @(negedge clock);
      clear_in();
      #1;
      chk("lu3_run_pc_write_c4", {31'd0, pcw3}, 32'd1);
      chk("lu3_run_bubble_c4", {31'd0, bub3}, 32'd0);
      chk("lu3_stall_cycles_total", sc3, 32'd3);
      chk("lu1_stall_cycles_total", {29'd0, sc1}, 32'd1);

      // zero register is never a hazard source or forwarded
      set_load_use(5'd31);
      mem_rd = 5'd31; mem_regwrite = 1'b1; ex_rn = 5'd31;
      wb_rd = 5'd31; wb_regwrite = 1'b1;
      #1;
      chk("xzr_no_stall", {31'd0, pcw3}, 32'd1);
      chk("xzr_no_fwd", {30'd0, fa3}, 32'd0);

      @(negedge clock);
      clear_in();
      mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
      ex_rm = 5'd5; ex_rn = 5'd6;
      #1;
      chk("xzr_stall_count", sc3, 32'd3);
      chk("fwd_b_exmem_prio", {30'd0, fb3}, 32'd2);
      chk("fwd_a_nomatch", {30'd0, fa3}, 32'd0);
      mem_regwrite = 1'b0;
      #1;
      chk("fwd_b_memwb", {30'd0, fb3}, 32'd1);

      @(negedge clock);
      clear_in();
      set_load_use(5'd2);
      #1;
      chk("br_pre_stall", {31'd0, pcw3}, 32'd0);

      @(negedge clock);
      clear_in();
      branch_taken = 1'b1;
      #1;
      chk("br3_if_id_flush", {31'd0, iff3}, 32'd1);
      chk("br3_bubble", {31'd0, bub3}, 32'd1);
      chk("br3_ex_mem_flush", {31'd0, emf3}, 32'd1);
      chk("br3_pc_write", {31'd0, pcw3}, 32'd1);
      chk("br2_ex_mem_flush", {31'd0, emf1}, 32'd0);
      chk("br2_bubble", {31'd0, bub1}, 32'd1);
      chk("br2_if_id_flush", {31'd0, iff1}, 32'd1);

      @(negedge clock);
      clear_in();
      #1;
      chk("br_run_pc_write", {31'd0, pcw3}, 32'd1);
      chk("br_run_bubble", {31'd0, bub3}, 32'd0);
      chk("br_stall_cycles", sc3, 32'd4);
      chk("br_flush_events", fe3, 32'd1);

      for (int i = 0; i < 8; i++) begin
         branch_taken = 1'b1;
         @(negedge clock);
      end
      clear_in();
      #1;
      chk("flush_sat_3bit", {29'd0, fe1}, 32'd7);
      chk("flush_count_32bit", fe3, 32'd9);

      // reset asserted between edges while the LOAD_LAT=3 instance is stalled
      set_load_use(5'd4);
      @(negedge clock);
      clear_in();
      #1;
      chk("mid_stall_pc_write", {31'd0, pcw3}, 32'd0);
      chk("mid_stall_count", sc3, 32'd5);
      reset = 1'b0;
      #1;
      chk("async_rst_stall_cycles", sc3, 32'd0);
      chk("async_rst_flush_events", fe3, 32'd0);
      chk("async_rst_pc_write", {31'd0, pcw3}, 32'd0);
      chk("async_rst_ex_mem_flush", {31'd0, emf3}, 32'd1);
      chk("async_rst_sc1", {29'd0, sc1}, 32'd0);

      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("post_rst_run_pc_write", {31'd0, pcw3}, 32'd1);
      chk("post_rst_run_bubble", {31'd0, bub3}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
